// File: rtl/btn_cmd_pkg.sv
// rtl/btn_cmd_pkg.sv - command codes and helpers shared with the pattern FSM
package btn_cmd_pkg;

    localparam int NUM_BTN = 4;

    typedef logic [NUM_BTN-1:0] cmd_t;

    localparam cmd_t CMD_NONE     = 4'h0;
    localparam cmd_t CMD_GO_S1    = 4'h1;
    localparam cmd_t CMD_GO_S2    = 4'h2;
    localparam cmd_t CMD_BACK_S1  = 4'h4;
    localparam cmd_t CMD_RESET_S0 = 4'h8;

    // Isolate the lowest set bit (bit 0 wins); returns 0 when v is 0.
    function automatic cmd_t lowest_set(input cmd_t v);
        return v & (~v + cmd_t'(1));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button: 2-FF synchroniser, debouncer and press detector
//  clk      in  1  clock
//  arst_in  in  1  asynchronous active-low reset
//  btn_raw  in  1  raw button, asynchronous to clk
//  press    out 1  high for one cycle when the debounced level rises
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic arst_in,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             s1;
    logic             s2;
    logic             deb;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge arst_in) begin
        if (!arst_in) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= btn_raw;
            s2    <= s1;
            deb_d <= deb;
            // Any sample agreeing with the accepted level restarts the count,
            // so only an unbroken run of DEBOUNCE_CYCLES differing samples flips deb.
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press = deb & ~deb_d;

endmodule

// File: rtl/btn_cmd_encoder.sv
// rtl/btn_cmd_encoder.sv - four bouncy buttons to serialised one-hot command codes
//  clk        in  1  clock
//  arst_in    in  1  asynchronous active-low reset
//  btn_in     in  4  raw buttons, bit i requests command (1<<i)
//  cmd_out    out 4  one-hot command for one cycle, 4'h0 when idle
//  cmd_valid  out 1  high iff cmd_out is non-zero
module btn_cmd_encoder
    import btn_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               arst_in,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] cmd_out,
    output logic               cmd_valid
);

    cmd_t press;
    cmd_t pend;
    cmd_t cand;
    cmd_t pick;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .arst_in (arst_in),
            .btn_raw (btn_in[i]),
            .press   (press[i])
        );
    end

    // Presses that lose arbitration wait in pend; a repeat press of a bit
    // already waiting merges into it.
    assign cand = pend | press;
    assign pick = lowest_set(cand);

    always_ff @(posedge clk or negedge arst_in) begin
        if (!arst_in) begin
            pend      <= CMD_NONE;
            cmd_out   <= CMD_NONE;
            cmd_valid <= 1'b0;
        end else begin
            pend      <= cand & ~pick;
            cmd_out   <= pick;
            cmd_valid <= |pick;
        end
    end

endmodule

// File: tb/tb_btn_cmd_encoder.sv
// tb/tb_btn_cmd_encoder.sv - randomized and directed bench against a behavioural model
module tb_btn_cmd_encoder;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       arst_in = 1'b0;
    logic [3:0] btn_in = 4'h0;
    logic [3:0] cmd_out;
    logic       cmd_valid;

    int n_cmp = 0;
    int n_bad = 0;

    btn_cmd_encoder #(.DEBOUNCE_CYCLES(N)) dut (
        .clk       (clk),
        .arst_in   (arst_in),
        .btn_in    (btn_in),
        .cmd_out   (cmd_out),
        .cmd_valid (cmd_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the synced level is btn_in two edges late; a button's
    // accepted level flips once the last N synced samples all disagree with it;
    // rising accepted levels become requests served lowest index first.
    logic [3:0] m_s1, m_s2, m_deb, m_debd, m_pend, exp_cmd;
    bit         hist [4][$];

    always @(posedge clk or negedge arst_in) begin
        if (!arst_in) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_debd = 0; m_pend = 0; exp_cmd = 0;
            for (int i = 0; i < 4; i++) hist[i].delete();
        end else begin
            logic [3:0] press, cand, pick;
            press  = m_deb & ~m_debd;
            m_debd = m_deb;
            for (int i = 0; i < 4; i++) begin
                bit all_diff;
                hist[i].push_back(m_s2[i]);
                if (hist[i].size() > N) void'(hist[i].pop_front());
                all_diff = (hist[i].size() == N);
                foreach (hist[i][k]) if (hist[i][k] == m_deb[i]) all_diff = 0;
                if (all_diff) m_deb[i] = ~m_deb[i];
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
            cand = m_pend | press;
            pick = 0;
            for (int i = 0; i < 4; i++) if (cand[i] && pick == 0) pick[i] = 1'b1;
            m_pend  = cand & ~pick;
            exp_cmd = pick;
        end
    end

    int         cyc = 0;
    int         n_seen = 0;
    int         last_cyc = 0;
    logic [3:0] last_cmd = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        check("cmd_out", 32'(cmd_out), 32'(exp_cmd));
        check("cmd_valid", 32'(cmd_valid), 32'(exp_cmd != 0));
        if (cmd_out != 0) begin
            n_seen++;
            last_cyc = cyc;
            last_cmd = cmd_out;
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_for(input logic [3:0] code, input string tag);
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            step(1);
            if (cmd_out == code) found = 1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int start, seen0;

        step(3);
        check("reset_cmd", 32'(cmd_out), 32'h0);
        check("reset_valid", 32'(cmd_valid), 32'h0);
        arst_in = 1'b1;
        step(5);

        // Clean press
        btn_in = 4'h2; start = cyc; seen0 = n_seen;
        step(40);
        check("clean_count", 32'(n_seen - seen0), 32'd1);
        check("clean_latency", 32'(last_cyc - start), 32'd19);
        check("clean_code", 32'(last_cmd), 32'h2);
        btn_in = 4'h0; seen0 = n_seen;
        step(40);
        check("release_none", 32'(n_seen - seen0), 32'd0);

        // Bounce
        seen0 = n_seen;
        for (int k = 0; k <= 10; k++) begin
            btn_in[0] = ~btn_in[0];
            if (k < 10) step(3);
        end
        check("bounce_quiet", 32'(n_seen - seen0), 32'd0);
        start = cyc;
        step(40);
        check("bounce_count", 32'(n_seen - seen0), 32'd1);
        check("bounce_latency", 32'(last_cyc - start), 32'd19);
        btn_in = 4'h0;
        step(40);

        // Glitch
        seen0 = n_seen;
        btn_in = 4'h8; step(10);
        btn_in = 4'h0; step(40);
        check("glitch_none", 32'(n_seen - seen0), 32'd0);

        // Simultaneous
        btn_in = 4'b1101; start = cyc; seen0 = n_seen;
        step(40);
        check("simul_count", 32'(n_seen - seen0), 32'd3);
        check("simul_last", 32'(last_cyc - start), 32'd21);
        check("simul_code", 32'(last_cmd), 32'h8);
        btn_in = 4'h0;
        step(40);

        // Reset mid-flight, then reissue with buttons still held
        btn_in = 4'b1100;
        wait_for(4'h4, "midflight_wait");
        arst_in = 1'b0;
        #1;
        check("midflight_async_cmd", 32'(cmd_out), 32'h0);
        check("midflight_async_valid", 32'(cmd_valid), 32'h0);
        step(1);
        arst_in = 1'b1; start = cyc; seen0 = n_seen;
        step(40);
        check("reissue_count", 32'(n_seen - seen0), 32'd2);
        check("reissue_last", 32'(last_cyc - start), 32'd20);
        check("reissue_code", 32'(last_cmd), 32'h8);
        btn_in = 4'h0;
        step(40);

        // Reset asserted mid-cycle while a command is showing, all buttons held
        btn_in = 4'hF;
        wait_for(4'h1, "rst_wait");
        arst_in = 1'b0;
        #1;
        check("rst_async_cmd", 32'(cmd_out), 32'h0);
        check("rst_async_valid", 32'(cmd_valid), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("rst_hold", 32'({cmd_valid, cmd_out}), 32'h0);
        end
        arst_in = 1'b1; start = cyc; seen0 = n_seen;
        step(40);
        check("held_rel_count", 32'(n_seen - seen0), 32'd4);
        check("held_rel_last", 32'(last_cyc - start), 32'd22);
        btn_in = 4'h0;
        step(40);

        // Randomized traffic, checked every cycle against the model
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                arst_in = 1'b0;
                step($urandom_range(1, 3));
                arst_in = 1'b1;
            end else if (r < 4) begin
                for (int k = 0; k < int'($urandom_range(5, 30)); k++) begin
                    btn_in = 4'($urandom);
                    step(1);
                end
            end else begin
                btn_in = 4'($urandom_range(0, 15));
                step($urandom_range(1, 40));
            end
        end
        btn_in = 4'h0;
        step(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
